// File: rtl/pcm_reader.sv
// PCM frame reader: on each accepted sample tick, pulls 1/2/4 bytes from the
// audio FIFO and presents them as signed 16-bit left/right samples.
module pcm_reader #(
  parameter bit ZERO_ON_UNDERRUN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_tick,
  input  logic        mode_16bit,
  input  logic        mode_stereo,
  input  logic [7:0]  fifo_rddata,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [15:0] left_sample,
  output logic [15:0] right_sample,
  output logic        sample_valid,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned SLOTS    = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_m16;
  logic              r_stereo;
  logic [CNT_W-1:0]  r_frame_len;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_captured;
  logic              r_pending;
  logic [BYTE_W-1:0] r_slot [SLOTS];

  logic              w_accept;
  logic              w_abort;
  logic              w_last;
  logic              w_capture;
  logic [CNT_W-1:0]  w_len_in;
  logic [BYTE_W-1:0] w_bytes [SLOTS];
  logic [SAMPLE_W-1:0] w_left;
  logic [SAMPLE_W-1:0] w_right;

  // Frame length in bytes for the mode bits presented at the tick
  always_comb begin
    case ({mode_16bit, mode_stereo})
      2'b00:   w_len_in = CNT_W'(1);
      2'b01:   w_len_in = CNT_W'(2);
      2'b10:   w_len_in = CNT_W'(2);
      default: w_len_in = CNT_W'(4);
    endcase
  end

  assign w_accept  = (r_state == S_IDLE) && sample_tick && enable;
  assign w_abort   = (r_state == S_FETCH) && fifo_empty && (r_issued < r_frame_len);
  assign w_capture = (r_state == S_FETCH) && r_pending && !w_abort;
  assign w_last    = w_capture && (r_captured == (r_frame_len - CNT_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and read strobe
  always_comb begin
    w_next     = r_state;
    fifo_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_FETCH;
      end
      S_FETCH: begin
        fifo_rd_en = !fifo_empty && (r_issued < r_frame_len);
        if (w_abort || w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Byte slots with the byte arriving this cycle merged in, so the final
  // capture and the output load share one edge
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      w_bytes[i] = r_slot[i];
    end
    w_bytes[r_captured[1:0]] = fifo_rddata;
  end

  // Slot-to-channel mapping; mono duplicates left onto right
  always_comb begin
    case ({r_m16, r_stereo})
      2'b00: begin
        w_left  = {w_bytes[0], 8'h00};
        w_right = {w_bytes[0], 8'h00};
      end
      2'b01: begin
        w_left  = {w_bytes[0], 8'h00};
        w_right = {w_bytes[1], 8'h00};
      end
      2'b10: begin
        w_left  = {w_bytes[1], w_bytes[0]};
        w_right = {w_bytes[1], w_bytes[0]};
      end
      default: begin
        w_left  = {w_bytes[1], w_bytes[0]};
        w_right = {w_bytes[3], w_bytes[2]};
      end
    endcase
  end

  // Datapath: mode latch, counters, byte capture, output load, underrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m16        <= 1'b0;
      r_stereo     <= 1'b0;
      r_frame_len  <= '0;
      r_issued     <= '0;
      r_captured   <= '0;
      r_pending    <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      sample_valid <= w_abort || w_last;
      r_pending    <= fifo_rd_en;

      if (w_accept) begin
        r_m16       <= mode_16bit;
        r_stereo    <= mode_stereo;
        r_frame_len <= w_len_in;
        r_issued    <= '0;
        r_captured  <= '0;
      end else begin
        if (fifo_rd_en) r_issued <= r_issued + CNT_W'(1);
        if (w_capture) begin
          r_slot[r_captured[1:0]] <= fifo_rddata;
          r_captured              <= r_captured + CNT_W'(1);
        end
      end

      if (w_last) begin
        left_sample  <= w_left;
        right_sample <= w_right;
      end else if (w_abort && ZERO_ON_UNDERRUN) begin
        left_sample  <= '0;
        right_sample <= '0;
      end

      // A new underrun outranks a simultaneous clear
      if (w_abort) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_reader.sv
// Directed bench for pcm_reader: two instances (zeroing / holding on underrun),
// each fed by its own behavioural FIFO with one-cycle read latency.
module tb_pcm_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic        sample_tick;
  logic        mode_16bit;
  logic        mode_stereo;
  logic        underrun_clr;
  logic [7:0]  rddata [2];
  logic        empty  [2];
  logic        rd_en  [2];
  logic [15:0] left   [2];
  logic [15:0] right  [2];
  logic        valid  [2];
  logic        urun   [2];

  logic [7:0] mem [2][64];
  int wp [2];
  int rp [2];

  int checks   = 0;
  int failures = 0;

  pcm_reader #(.ZERO_ON_UNDERRUN(1'b1)) u_zero (
    .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
    .mode_16bit(mode_16bit), .mode_stereo(mode_stereo),
    .fifo_rddata(rddata[0]), .fifo_empty(empty[0]), .fifo_rd_en(rd_en[0]),
    .left_sample(left[0]), .right_sample(right[0]), .sample_valid(valid[0]),
    .underrun(urun[0]), .underrun_clr(underrun_clr)
  );

  pcm_reader #(.ZERO_ON_UNDERRUN(1'b0)) u_hold (
    .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
    .mode_16bit(mode_16bit), .mode_stereo(mode_stereo),
    .fifo_rddata(rddata[1]), .fifo_empty(empty[1]), .fifo_rd_en(rd_en[1]),
    .left_sample(left[1]), .right_sample(right[1]), .sample_valid(valid[1]),
    .underrun(urun[1]), .underrun_clr(underrun_clr)
  );

  assign empty[0] = (wp[0] == rp[0]);
  assign empty[1] = (wp[1] == rp[1]);

  // FIFO models: data appears the cycle after the strobe; reset flushes
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rp[i] <= wp[i];
      end else if (rd_en[i] && !empty[i]) begin
        rddata[i] <= mem[i][rp[i][5:0]];
        rp[i]     <= rp[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      mem[i][wp[i][5:0]] = b;
      wp[i] = wp[i] + 1;
    end
  endtask

  // Tick in cycle 0, observe cycles 1..14 at the falling edge
  task automatic run_frame(input bit m16, input bit st, input bit perturb,
                           input int clr_at, input int exp_cyc, input int exp_strobes,
                           input string tag);
    int s0;
    int s1;
    int first;
    int nvalid;
    s0 = rp[0];
    s1 = rp[1];
    first = -1;
    nvalid = 0;
    @(negedge clk);
    mode_16bit  = m16;
    mode_stereo = st;
    enable      = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (valid[0]) begin
        if (first < 0) first = c;
        nvalid++;
      end
      if (perturb && c == 1) begin
        mode_16bit  = !m16;
        mode_stereo = !st;
        enable      = 1'b0;
      end
      underrun_clr = (c == clr_at);
      @(negedge clk);
    end
    underrun_clr = 1'b0;
    enable       = 1'b1;
    chk({tag, " valid_cycle"}, first, exp_cyc);
    chk({tag, " valid_count"}, nvalid, 1);
    chk({tag, " strobes"}, rp[0] - s0, exp_strobes);
    chk({tag, " strobes_hold"}, rp[1] - s1, exp_strobes);
  endtask

  initial begin
    int nv;
    int nr;
    wp[0] = 0;
    wp[1] = 0;
    rst = 1'b1;
    enable = 1'b0;
    sample_tick = 1'b0;
    mode_16bit = 1'b0;
    mode_stereo = 1'b0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst left", 32'(left[0]), 32'h0);
    chk("rst right", 32'(right[0]), 32'h0);
    chk("rst valid", 32'(valid[0]), 32'h0);
    chk("rst underrun", 32'(urun[0]), 32'h0);
    chk("rst rd_en", 32'(rd_en[0]), 32'h0);
    rst = 1'b0;

    push(8'h80);
    run_frame(1'b0, 1'b0, 1'b0, -1, 3, 1, "m8");
    chk("m8 left", 32'(left[0]), 32'h8000);
    chk("m8 right", 32'(right[0]), 32'h8000);

    push(8'h34); push(8'h12); push(8'h78); push(8'h56);
    run_frame(1'b1, 1'b1, 1'b0, -1, 6, 4, "s16");
    chk("s16 left", 32'(left[0]), 32'h1234);
    chk("s16 right", 32'(right[0]), 32'h5678);
    chk("s16 left_hold", 32'(left[1]), 32'h1234);

    push(8'h7F); push(8'h01);
    run_frame(1'b0, 1'b1, 1'b0, -1, 4, 2, "s8");
    chk("s8 left", 32'(left[0]), 32'h7F00);
    chk("s8 right", 32'(right[0]), 32'h0100);
    chk("s8 underrun", 32'(urun[0]), 32'h0);

    push(8'hAA); push(8'hBB);
    run_frame(1'b1, 1'b1, 1'b0, -1, 4, 2, "ur");
    chk("ur left", 32'(left[0]), 32'h0);
    chk("ur right", 32'(right[0]), 32'h0);
    chk("ur underrun", 32'(urun[0]), 32'h1);
    chk("ur left_hold", 32'(left[1]), 32'h7F00);
    chk("ur right_hold", 32'(right[1]), 32'h0100);
    chk("ur underrun_hold", 32'(urun[1]), 32'h1);
    @(negedge clk); underrun_clr = 1'b1;
    @(negedge clk); underrun_clr = 1'b0;
    chk("clr underrun", 32'(urun[0]), 32'h0);
    chk("clr underrun_hold", 32'(urun[1]), 32'h0);

    push(8'h34); push(8'h12); push(8'h78); push(8'h56);
    run_frame(1'b1, 1'b1, 1'b0, -1, 6, 4, "s16b");
    chk("s16b right_hold", 32'(right[1]), 32'h5678);

    // Empty at tick, with a clear landing on the same edge as the set
    run_frame(1'b1, 1'b1, 1'b0, 1, 2, 0, "emp");
    chk("emp left_hold", 32'(left[1]), 32'h1234);
    chk("emp right_hold", 32'(right[1]), 32'h5678);
    chk("emp underrun_hold", 32'(urun[1]), 32'h1);
    chk("emp left", 32'(left[0]), 32'h0);
    chk("emp underrun", 32'(urun[0]), 32'h1);
    @(negedge clk); underrun_clr = 1'b1;
    @(negedge clk); underrun_clr = 1'b0;
    chk("emp clr", 32'(urun[0]), 32'h0);

    // Mode flip and enable drop mid-frame must not disturb the frame
    push(8'h55); push(8'hAA);
    run_frame(1'b0, 1'b0, 1'b1, -1, 3, 1, "pert");
    chk("pert left", 32'(left[0]), 32'h5500);
    chk("pert right", 32'(right[0]), 32'h5500);

    // Reset in cycle 2 of a 4-byte frame
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    @(negedge clk);
    mode_16bit = 1'b1; mode_stereo = 1'b1; enable = 1'b1; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    chk("rstmid rd_en_c1", 32'(rd_en[0]), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rstmid left", 32'(left[0]), 32'h0);
    chk("rstmid right", 32'(right[0]), 32'h0);
    chk("rstmid rd_en", 32'(rd_en[0]), 32'h0);
    chk("rstmid left_hold", 32'(left[1]), 32'h0);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid[0] || valid[1]) nv++;
      @(negedge clk);
    end
    chk("rstmid no_valid", nv, 0);

    // Tick with enable low is ignored
    push(8'h80);
    @(negedge clk); enable = 1'b0; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    nr = 0;
    for (int c = 0; c < 8; c++) begin
      if (rd_en[0]) nr++;
      @(negedge clk);
    end
    chk("dis no_strobe", nr, 0);
    run_frame(1'b0, 1'b0, 1'b0, -1, 3, 1, "after");
    chk("after left", 32'(left[0]), 32'h8000);
    chk("after right", 32'(right[0]), 32'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
